// File: rtl/ysyx_24080006_ifu.sv
// Instruction fetch unit: fetch PC, 2-deep outstanding-request tag queue and 2-entry {inst, pc} FIFO.
// Define YSYX_24080006_IFU_MISALIGN_EN to turn misaligned redirects into a single flagged NOP entry.
module ysyx_24080006_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_misalign
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 2;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tag0;
  logic [XLEN-1:0] tag1;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [XLEN-1:0] head_inst;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] tail_inst;
  logic [XLEN-1:0] tail_pc;

  logic            req_fire_c;
  logic            rsp_take_c;
  logic            rsp_drop_c;
  logic            rsp_push_c;
  logic            pop_c;
  logic            push_c;
  logic            mis_push_c;
  logic            halt_c;
  logic [XLEN-1:0] tgt_c;
  logic [XLEN-1:0] push_inst_c;
  logic [XLEN-1:0] push_pc_c;
  logic [CW-1:0]   fifo_wr_idx_c;
  logic [CW-1:0]   tag_wr_idx_c;

`ifdef YSYX_24080006_IFU_MISALIGN_EN
  logic halted;
  logic mis_pend;
  logic head_mis;
  logic tail_mis;

  assign tgt_c      = redirect_pc;
  assign halt_c     = halted;
  assign mis_push_c = mis_pend & ~redirect_valid;

  // A misaligned target parks fetch; the flagged entry is pushed the cycle after the flush.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      halted   <= 1'b0;
      mis_pend <= 1'b0;
    end else if (redirect_valid) begin
      halted   <= (redirect_pc[1:0] != 2'b00);
      mis_pend <= (redirect_pc[1:0] != 2'b00);
    end else begin
      mis_pend <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      head_mis <= 1'b0;
      tail_mis <= 1'b0;
    end else if (redirect_valid) begin
      head_mis <= 1'b0;
    end else begin
      if (pop_c) head_mis <= tail_mis;
      if (push_c) begin
        if (fifo_wr_idx_c == '0) head_mis <= mis_push_c;
        else                     tail_mis <= mis_push_c;
      end
    end
  end

  assign inst_misalign = head_mis;
`else
  assign tgt_c         = redirect_pc & 32'hFFFF_FFFC;
  assign halt_c        = 1'b0;
  assign mis_push_c    = 1'b0;
  assign inst_misalign = 1'b0;
`endif

  // Dropped requests still occupy a slot, so one response always has FIFO room.
  assign imem_req_valid = rst_n & ~redirect_valid & ~halt_c &
                          ((3'(out_cnt) + 3'(fifo_cnt)) < 3'd2);
  assign imem_req_addr  = pc;
  assign req_fire_c     = imem_req_valid & imem_req_ready;

  assign rsp_take_c    = imem_rsp_valid & (out_cnt != '0);
  assign rsp_drop_c    = rsp_take_c & (redirect_valid | (drop_cnt != '0));
  assign rsp_push_c    = rsp_take_c & ~rsp_drop_c;
  assign pop_c         = inst_valid & inst_ready & ~redirect_valid;
  assign push_c        = rsp_push_c | mis_push_c;
  assign push_inst_c   = mis_push_c ? NOP_INST : imem_rsp_data;
  assign push_pc_c     = mis_push_c ? pc : tag0;
  assign fifo_wr_idx_c = fifo_cnt - CW'(pop_c);
  assign tag_wr_idx_c  = out_cnt - CW'(rsp_take_c);

  assign inst_valid = (fifo_cnt != '0);
  assign inst       = head_inst;
  assign inst_pc    = head_pc;

  // Fetch PC
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= tgt_c;
    end else if (req_fire_c) begin
      pc <= pc + 32'd4;
    end
  end

  // In-order tag queue; everything in flight at a redirect becomes a drop.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
      tag0     <= '0;
      tag1     <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(req_fire_c) - CW'(rsp_take_c);
      if (redirect_valid) begin
        drop_cnt <= tag_wr_idx_c;
      end else if (rsp_drop_c) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (rsp_take_c) tag0 <= tag1;
      if (req_fire_c) begin
        if (tag_wr_idx_c == '0) tag0 <= pc;
        else                    tag1 <= pc;
      end
    end
  end

  // Instruction FIFO, head at entry 0
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt  <= '0;
      head_inst <= '0;
      head_pc   <= '0;
      tail_inst <= '0;
      tail_pc   <= '0;
    end else if (redirect_valid) begin
      fifo_cnt <= '0;
    end else begin
      fifo_cnt <= fifo_cnt + CW'(push_c) - CW'(pop_c);
      if (pop_c) begin
        head_inst <= tail_inst;
        head_pc   <= tail_pc;
      end
      if (push_c) begin
        if (fifo_wr_idx_c == '0) begin
          head_inst <= push_inst_c;
          head_pc   <= push_pc_c;
        end else begin
          tail_inst <= push_inst_c;
          tail_pc   <= push_pc_c;
        end
      end
    end
  end

endmodule

// File: doc/ysyx_24080006_ifu.md
YSYX_24080006_IFU -- requirements
Module: ysyx_24080006_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have port clock  input  1  single clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port redirect_valid  input  1  branch/jump/trap redirect request from execute.
REQ-005 SHALL have port redirect_pc  input  32  redirect target.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_req_addr  output  32  fetch address, word aligned.
REQ-009 SHALL have port imem_rsp_valid  input  1  in-order response, no backpressure.
REQ-010 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-011 SHALL have port inst_valid  output  1  instruction available to decode/immediate stage.
REQ-012 SHALL have port inst_ready  input  1  decode accepts instruction.
REQ-013 SHALL have port inst  output  32  instruction word to decode.
REQ-014 SHALL have port inst_pc  output  32  address of inst.
REQ-015 SHALL have port inst_misalign  output  1  misaligned-fetch flag accompanying inst.

Function
REQ-016 SHALL hold fetch PC register; request handshake (valid&ready) advances PC by 4, wrapping modulo 2^32.
REQ-017 SHALL keep imem_req_addr equal to fetch PC and stable while imem_req_valid & !imem_req_ready, except on redirect.
REQ-018 SHALL keep 2-entry in-order pc tag queue for outstanding requests; responses consume tags in order.
REQ-019 SHALL keep 2-entry FIFO of {inst, pc}; response written in cycle of imem_rsp_valid, visible as inst_valid next cycle (1-cycle latency, no bypass).
REQ-020 SHALL assert imem_req_valid only when outstanding + FIFO occupancy < 2 and redirect_valid low; a response never finds FIFO full.
REQ-021 SHALL drive inst_valid = FIFO non-empty, inst/inst_pc from head; pop on inst_valid & inst_ready; push and pop allowed in same cycle.
REQ-022 SHALL on redirect_valid: flush FIFO (inst_valid low next cycle), load PC with redirect_pc, mark all in-flight requests as drop; request issue resumes next cycle.
REQ-023 SHALL discard dropped responses (including one arriving in redirect cycle) without FIFO write; drop count decrements per discarded response.
REQ-024 SHALL give redirect priority over simultaneous request handshake, response push, and decode pop.
REQ-025 SHALL count dropped requests toward 2-request limit until discarded.
REQ-026 SHALL limit outstanding requests to 2; memory responds at most one per cycle.

Reset
REQ-027 SHALL on rst_n low asynchronously set PC=RESET_PC, FIFO, tag queue, drop count empty; imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_misalign=0.
REQ-028 SHALL issue first request (addr RESET_PC) in first cycle after rst_n deasserts; responses arriving during reset ignored; reset mid-transaction abandons all in-flight state.

Configuration
REQ-029 SHALL with YSYX_24080006_IFU_MISALIGN_EN defined: redirect_pc[1:0]!=0 stops fetching (no request), pushes one entry inst=32'h0000_0013, inst_pc=redirect_pc, inst_misalign=1, idles until next redirect.
REQ-030 SHALL without YSYX_24080006_IFU_MISALIGN_EN: redirect_pc[1:0] forced to 0, inst_misalign tied 0.

Verification
REQ-031 SHALL cover: reset release, req_ready=1, rsp 1 cycle later with 0x00500093 -> addr 0x80000000 then 0x80000004; inst_valid with inst=0x00500093, inst_pc=0x80000000 two cycles after request.
REQ-032 SHALL cover: inst_ready=0 for 10 cycles -> exactly 2 requests issued, FIFO holds 0x80000000/0x80000004, no more requests until pop.
REQ-033 SHALL cover: redirect to 0x80001000 with 2 outstanding -> both responses discarded, next inst_pc=0x80001000.
REQ-034 SHALL cover: redirect in same cycle as response and decode pop -> response dropped, FIFO empty next cycle, req addr 0x80001000.
REQ-035 SHALL cover: imem_req_ready=0 for 5 cycles -> imem_req_addr stable at 0x80000000.
REQ-036 SHALL cover: macro on, redirect to 0x80000002 -> inst_misalign=1, inst=0x00000013, inst_pc=0x80000002, no request; macro off -> fetch from 0x80000000.
